id_ex_register: RTL and testbench
=================================

// Module: id_ex_register
// PURPOSE
//   ID/EX pipeline register with integrated load-use hazard detection.
//   Captures decode outputs: register-file reads, sign-extended immediate, register specifiers and control bits.
//   Presents them to EX one cycle later.
//   Stalls PC and IF/ID and inserts a bubble when EX holds a load whose target is read by the instruction in ID.
//   Supports branch flush and downstream hold. Keeps a saturating stall-cycle counter.
// PARAMETERS
//   DATA_W      32  datapath width (pc_plus4, reg data, immediate)
//   REG_ADDR_W  5   register specifier width
//   CNT_W       16  stall counter width
// PORTS
//   clk               in   1           rising-edge clock
//   reset_n           in   1           synchronous active-low reset
//   flush             in   1           branch taken/redirect: kill instruction entering EX
//   hold              in   1           downstream stall: freeze ID/EX contents
//   id_valid          in   1           ID holds a real instruction
//   id_pc_plus4       in   DATA_W      PC+4 of ID instruction
//   id_rd_data1       in   DATA_W      register file read port 1
//   id_rd_data2       in   DATA_W      register file read port 2
//   id_imm_ext        in   DATA_W      sign-extended immediate from decode sign-extender
//   id_rs, id_rt, id_rd in REG_ADDR_W  register specifiers
//   id_uses_rt        in   1           ID instruction reads rt (R-type, store, beq)
//   id_ctrl           in   8           {reg_write,mem_to_reg,mem_read,mem_write,alu_src,reg_dst,alu_op[1:0]}
//   stall_out         out  1           load-use stall to PC and IF/ID write-enable (active high)
//   ex_valid          out  1           EX holds a real instruction
//   ex_pc_plus4, ex_rd_data1, ex_rd_data2, ex_imm_ext  out DATA_W  registered copies
//   ex_rs, ex_rt, ex_rd out  REG_ADDR_W  registered specifiers
//   ex_ctrl           out  8           registered control bundle
//   stall_count       out  CNT_W       saturating count of load-use stall cycles
// BEHAVIOUR
//   - Reset (reset_n=0 at posedge): all ex_* outputs <= 0, ex_valid <= 0, stall_count <= 0.
//     Reset mid-operation discards the in-flight instruction.
//   - Hazard, combinational from current state and ID inputs:
//     load_use = ex_valid & ex_ctrl.mem_read & (ex_rt!=0)
//                & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
//   - stall_out = id_valid & load_use & ~flush & ~hold.
//     It is driven combinationally in the same cycle; hold and flush mask it.
//   - Next-state priority per posedge:
//     1. reset
//     2. flush: bubble
//     3. hold: all ex_* keep their values
//     4. stall_out: bubble
//     5. normal: ex_* <= id_*, ex_valid <= id_valid
//   - Bubble: ex_valid=0, ex_ctrl=0, all data/specifier fields=0. The bubble is deterministic and the bench checks it.
//   - If id_valid=0 under normal load, ex_ctrl <= 0 regardless of id_ctrl.
//   - Latency: 1 cycle ID->EX. A stall lasts exactly 1 cycle per load-use pair.
//     The next cycle EX holds a bubble, so load_use=0.
//   - $zero: ex_rt==0 never stalls.
//   - Simultaneous flush+hold: flush wins, bubble loaded.
//   - Simultaneous flush+hazard: no stall, bubble loaded.
//   - stall_count increments on each cycle with stall_out=1. It saturates at 2^CNT_W-1 with no wrap.
//     It holds during hold and clears only on reset.
// STRUCTURE
//   - Shared header mips_defines.vh holds:
//     - CTRL_W=8 and control-bit index constants (CTRL_REG_WRITE..CTRL_ALU_OP)
//     - ALU_OP encodings (00 add, 01 sub, 10 funct)
//     - CTRL_BUBBLE=8'h00
//   - One sub-module: hazard_detect_unit (combinational load_use/stall_out). It is reused if forwarding is added.
//   - Register bank and stall counter stay in this module.
// TESTING
//   - Reset: hold reset_n=0 for 2 cycles with nonzero ID inputs.
//     -> all ex_* = 0, stall_count=0, stall_out=0.
//   - Pass-through: id_imm_ext=32'hFFFF8000, id_ctrl=8'hA2, id_valid=1.
//     -> next cycle ex_imm_ext=32'hFFFF8000, ex_ctrl=8'hA2, ex_valid=1.
//   - Load-use on rs: EX=lw (mem_read=1) with ex_rt=5; ID id_rs=5.
//     -> stall_out=1 for 1 cycle, next ex_valid=0, ex_ctrl=0, stall_count=1.
//     -> the following cycle the ID instruction enters EX.
//   - No false stall:
//     - ex_rt=0: no stall.
//     - ex_rt=5 matching id_rt with id_uses_rt=0: no stall.
//     - mem_read=0: no stall.
//     -> stall_out=0 and normal load in all three cases.
//   - Flush vs hazard/hold: assert flush with a hazard pending, then flush with hold=1.
//     -> stall_out=0, bubble loaded in both cases.
//     - hold alone: ex_* unchanged for 3 cycles.
//   - Saturation: CNT_W=2, force 5 consecutive hazards.
//     -> stall_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_register_pkg.sv
// Shared control-bundle layout and ALU-op encodings for the ID/EX stage.
package id_ex_register_pkg;

    // Control bundle: {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, alu_op[1:0]}
    localparam int unsigned CTRL_W          = 8;
    localparam int unsigned CTRL_REG_WRITE  = 7;
    localparam int unsigned CTRL_MEM_TO_REG = 6;
    localparam int unsigned CTRL_MEM_READ   = 5;
    localparam int unsigned CTRL_MEM_WRITE  = 4;
    localparam int unsigned CTRL_ALU_SRC    = 3;
    localparam int unsigned CTRL_REG_DST    = 2;
    localparam int unsigned CTRL_ALU_OP     = 0;  // lsb of the 2-bit alu_op field
    localparam int unsigned CTRL_ALU_OP_W   = 2;

    typedef enum logic [CTRL_ALU_OP_W-1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

    // A bubble carries no side effects: every control bit cleared.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 8'h00;

    function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational load-use hazard detection between the EX-stage load and the ID instruction.
module hazard_detect_unit #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  flush_i,
    input  logic                  hold_i,
    output logic                  load_use_o,
    output logic                  stall_o
);

    logic rt_nonzero;
    logic rs_match;
    logic rt_match;

    // A load into $zero never produces a dependency.
    always_comb begin
        rt_nonzero = (ex_rt_i != '0);
        rs_match   = (ex_rt_i == id_rs_i);
        rt_match   = id_uses_rt_i && (ex_rt_i == id_rt_i);
        load_use_o = ex_valid_i && ex_mem_read_i && rt_nonzero && (rs_match || rt_match);
        // Flush kills the ID instruction and hold freezes the pipe, so neither needs a stall.
        stall_o    = id_valid_i && load_use_o && !flush_i && !hold_i;
    end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use stall generation and a saturating stall counter.
module id_ex_register
    import id_ex_register_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  hold,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc_plus4,
    input  logic [DATA_W-1:0]     id_rd_data1,
    input  logic [DATA_W-1:0]     id_rd_data2,
    input  logic [DATA_W-1:0]     id_imm_ext,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rt,
    input  logic [CTRL_W-1:0]     id_ctrl,
    output logic                  stall_out,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc_plus4,
    output logic [DATA_W-1:0]     ex_rd_data1,
    output logic [DATA_W-1:0]     ex_rd_data2,
    output logic [DATA_W-1:0]     ex_imm_ext,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [CNT_W-1:0]      stall_count
);

    logic                  valid_q,  valid_d;
    logic [DATA_W-1:0]     pc_q,     pc_d;
    logic [DATA_W-1:0]     data1_q,  data1_d;
    logic [DATA_W-1:0]     data2_q,  data2_d;
    logic [DATA_W-1:0]     imm_q,    imm_d;
    logic [REG_ADDR_W-1:0] rs_q,     rs_d;
    logic [REG_ADDR_W-1:0] rt_q,     rt_d;
    logic [REG_ADDR_W-1:0] rd_q,     rd_d;
    logic [CTRL_W-1:0]     ctrl_q,   ctrl_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic                  load_use;
    logic                  stall;

    hazard_detect_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard (
        .ex_valid_i   (valid_q),
        .ex_mem_read_i(ctrl_is_load(ctrl_q)),
        .ex_rt_i      (rt_q),
        .id_valid_i   (id_valid),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_uses_rt_i (id_uses_rt),
        .flush_i      (flush),
        .hold_i       (hold),
        .load_use_o   (load_use),
        .stall_o      (stall)
    );

    // Next-state selection: flush > hold > stall bubble > normal capture.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data1_d = data1_q;
        data2_d = data2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        if (flush || (!hold && stall)) begin
            valid_d = 1'b0;
            pc_d    = '0;
            data1_d = '0;
            data2_d = '0;
            imm_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            ctrl_d  = CTRL_BUBBLE;
        end else if (!hold) begin
            valid_d = id_valid;
            pc_d    = id_pc_plus4;
            data1_d = id_rd_data1;
            data2_d = id_rd_data2;
            imm_d   = id_imm_ext;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            // An invalid ID slot must not carry side-effecting control into EX.
            ctrl_d  = id_valid ? id_ctrl : CTRL_BUBBLE;
        end
    end

    // Stall counter saturates at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline and counter state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    // load_use is exported by the hazard unit for future forwarding logic.
    logic unused_load_use;
    assign unused_load_use = load_use;

    assign stall_out   = stall;
    assign ex_valid    = valid_q;
    assign ex_pc_plus4 = pc_q;
    assign ex_rd_data1 = data1_q;
    assign ex_rd_data2 = data2_q;
    assign ex_imm_ext  = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;
    assign ex_ctrl     = ctrl_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed self-checking bench for id_ex_register.
module tb_id_ex_register;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        hold;
    logic        id_valid;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_rd_data1;
    logic [31:0] id_rd_data2;
    logic [31:0] id_imm_ext;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_uses_rt;
    logic [7:0]  id_ctrl;

    logic        stall_out,   s_stall_out;
    logic        ex_valid,    s_ex_valid;
    logic [31:0] ex_pc_plus4, s_ex_pc_plus4;
    logic [31:0] ex_rd_data1, s_ex_rd_data1;
    logic [31:0] ex_rd_data2, s_ex_rd_data2;
    logic [31:0] ex_imm_ext,  s_ex_imm_ext;
    logic [4:0]  ex_rs,       s_ex_rs;
    logic [4:0]  ex_rt,       s_ex_rt;
    logic [4:0]  ex_rd,       s_ex_rd;
    logic [7:0]  ex_ctrl,     s_ex_ctrl;
    logic [15:0] stall_count;
    logic [1:0]  s_stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [7:0] CtrlLw  = 8'hE8;  // reg_write, mem_to_reg, mem_read, alu_src
    localparam logic [7:0] CtrlR   = 8'h86;  // reg_write, reg_dst, alu_op=funct
    localparam logic [7:0] CtrlImm = 8'h8A;  // reg_write, alu_src, alu_op=funct

    always #5 clk = ~clk;

    id_ex_register dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .hold(hold), .id_valid(id_valid),
        .id_pc_plus4(id_pc_plus4), .id_rd_data1(id_rd_data1), .id_rd_data2(id_rd_data2),
        .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_rd_data1(ex_rd_data1),
        .ex_rd_data2(ex_rd_data2), .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .stall_count(stall_count)
    );

    id_ex_register #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .flush(flush), .hold(hold), .id_valid(id_valid),
        .id_pc_plus4(id_pc_plus4), .id_rd_data1(id_rd_data1), .id_rd_data2(id_rd_data2),
        .id_imm_ext(id_imm_ext), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl), .stall_out(s_stall_out),
        .ex_valid(s_ex_valid), .ex_pc_plus4(s_ex_pc_plus4), .ex_rd_data1(s_ex_rd_data1),
        .ex_rd_data2(s_ex_rd_data2), .ex_imm_ext(s_ex_imm_ext), .ex_rs(s_ex_rs),
        .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_ctrl(s_ex_ctrl), .stall_count(s_stall_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic uses_rt, input logic [7:0] ctrl);
        id_valid    = v;
        id_pc_plus4 = pc;
        id_rd_data1 = pc ^ 32'h1111_1111;
        id_rd_data2 = pc ^ 32'h2222_2222;
        id_imm_ext  = imm;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_uses_rt  = uses_rt;
        id_ctrl     = ctrl;
        #1;
    endtask

    task automatic test_reset();
        flush = 1'b0;
        hold  = 1'b0;
        reset_n = 1'b0;
        set_id(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7, 5'd8, 5'd9, 1'b1, 8'hFF);
        step();
        step();
        n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
        n_tests++; if (ex_ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got %h exp 00", ex_ctrl); end
        n_tests++; if (ex_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", ex_pc_plus4); end
        n_tests++; if (ex_imm_ext !== 32'h0 || ex_rd_data1 !== 32'h0 || ex_rd_data2 !== 32'h0) begin
            n_fail++; $display("FAIL reset_data got %h/%h/%h exp 0", ex_imm_ext, ex_rd_data1, ex_rd_data2); end
        n_tests++; if ({ex_rs, ex_rt, ex_rd} !== 15'h0) begin n_fail++; $display("FAIL reset_regs got %h exp 0", {ex_rs, ex_rt, ex_rd}); end
        n_tests++; if (stall_count !== 16'h0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", stall_count); end
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall_out); end
        reset_n = 1'b1;
    endtask

    task automatic test_pass_through();
        set_id(1'b1, 32'h0000_0100, 32'hFFFF_8000, 5'd1, 5'd2, 5'd3, 1'b1, 8'hA2);
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL pass_stall got %b exp 0", stall_out); end
        step();
        n_tests++; if (ex_imm_ext !== 32'hFFFF_8000) begin n_fail++; $display("FAIL pass_imm got %h exp FFFF8000", ex_imm_ext); end
        n_tests++; if (ex_ctrl !== 8'hA2) begin n_fail++; $display("FAIL pass_ctrl got %h exp A2", ex_ctrl); end
        n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid got %b exp 1", ex_valid); end
        n_tests++; if (ex_pc_plus4 !== 32'h100 || ex_rd_data1 !== 32'h1111_1011) begin
            n_fail++; $display("FAIL pass_data got %h/%h exp 100/11111011", ex_pc_plus4, ex_rd_data1); end
        n_tests++; if ({ex_rs, ex_rt, ex_rd} !== {5'd1, 5'd2, 5'd3}) begin
            n_fail++; $display("FAIL pass_regs got %0d/%0d/%0d exp 1/2/3", ex_rs, ex_rt, ex_rd); end
    endtask

    task automatic test_load_use();
        // lw $5, reads only rs=1; EX holds a load to $2, so no dependency
        set_id(1'b1, 32'h104, 32'h4, 5'd1, 5'd5, 5'd0, 1'b0, CtrlLw);
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL lu_pre_stall got %b exp 0", stall_out); end
        step();
        set_id(1'b1, 32'h108, 32'h0, 5'd5, 5'd6, 5'd7, 1'b1, CtrlR);
        n_tests++; if (stall_out !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b exp 1", stall_out); end
        step();
        n_tests++; if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00) begin
            n_fail++; $display("FAIL lu_bubble got valid=%b ctrl=%h exp 0/00", ex_valid, ex_ctrl); end
        n_tests++; if (ex_pc_plus4 !== 32'h0 || ex_rs !== 5'd0 || ex_rt !== 5'd0) begin
            n_fail++; $display("FAIL lu_bubble_data got %h/%0d/%0d exp 0", ex_pc_plus4, ex_rs, ex_rt); end
        n_tests++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_count got %0d exp 1", stall_count); end
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL lu_release got %b exp 0", stall_out); end
        step();
        n_tests++; if (ex_valid !== 1'b1 || ex_ctrl !== CtrlR || ex_rs !== 5'd5 || ex_pc_plus4 !== 32'h108) begin
            n_fail++; $display("FAIL lu_enter got %b/%h/%0d/%h exp 1/86/5/108", ex_valid, ex_ctrl, ex_rs, ex_pc_plus4); end
        n_tests++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_count_hold got %0d exp 1", stall_count); end
    endtask

    task automatic test_no_false_stall();
        // Load to $zero followed by a reader of $zero
        set_id(1'b1, 32'h200, 32'h0, 5'd1, 5'd0, 5'd0, 1'b0, CtrlLw);
        step();
        set_id(1'b1, 32'h204, 32'h0, 5'd0, 5'd0, 5'd4, 1'b1, CtrlR);
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL nfs_zero got %b exp 0", stall_out); end
        step();
        n_tests++; if (ex_valid !== 1'b1 || ex_ctrl !== CtrlR || ex_pc_plus4 !== 32'h204) begin
            n_fail++; $display("FAIL nfs_zero_load got %b/%h/%h exp 1/86/204", ex_valid, ex_ctrl, ex_pc_plus4); end
        // rt matches but ID does not read rt
        set_id(1'b1, 32'h208, 32'h0, 5'd1, 5'd5, 5'd0, 1'b0, CtrlLw);
        step();
        set_id(1'b1, 32'h20C, 32'h10, 5'd7, 5'd5, 5'd0, 1'b0, CtrlImm);
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL nfs_uses_rt got %b exp 0", stall_out); end
        step();
        n_tests++; if (ex_valid !== 1'b1 || ex_ctrl !== CtrlImm || ex_rt !== 5'd5 || ex_imm_ext !== 32'h10) begin
            n_fail++; $display("FAIL nfs_uses_rt_load got %b/%h/%0d/%h exp 1/8A/5/10", ex_valid, ex_ctrl, ex_rt, ex_imm_ext); end
        // EX writes $5 but is not a load
        set_id(1'b1, 32'h210, 32'h0, 5'd5, 5'd5, 5'd6, 1'b1, CtrlR);
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL nfs_no_load got %b exp 0", stall_out); end
        step();
        n_tests++; if (ex_valid !== 1'b1 || ex_ctrl !== CtrlR || ex_rs !== 5'd5 || ex_pc_plus4 !== 32'h210) begin
            n_fail++; $display("FAIL nfs_no_load_load got %b/%h/%0d/%h exp 1/86/5/210", ex_valid, ex_ctrl, ex_rs, ex_pc_plus4); end
        // Invalid ID slot loads a zero control bundle
        set_id(1'b0, 32'h214, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 8'hFF);
        step();
        n_tests++; if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || ex_pc_plus4 !== 32'h214) begin
            n_fail++; $display("FAIL nfs_invalid got %b/%h/%h exp 0/00/214", ex_valid, ex_ctrl, ex_pc_plus4); end
    endtask

    task automatic test_flush_hold();
        set_id(1'b1, 32'h300, 32'h0, 5'd1, 5'd5, 5'd0, 1'b0, CtrlLw);
        step();
        set_id(1'b1, 32'h304, 32'h0, 5'd5, 5'd6, 5'd7, 1'b1, CtrlR);
        flush = 1'b1;
        #1;
        n_tests++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL flush_hazard_stall got %b exp 0", stall_out); end
        step();
        n_tests++; if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || ex_pc_plus4 !== 32'h0 || ex_rs !== 5'd0) begin
            n_fail++; $display("FAIL flush_hazard_bubble got %b/%h/%h/%0d exp 0", ex_valid, ex_ctrl, ex_pc_plus4, ex_rs); end
        n_tests++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL flush_count got %0d exp 1", stall_count); end
        flush = 1'b0;
        set_id(1'b1, 32'h308, 32'h0, 5'd3, 5'd4, 5'd5, 1'b1, CtrlR);
        step();
        flush = 1'b1;
        hold  = 1'b1;
        step();
        n_tests++; if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || ex_pc_plus4 !== 32'h0 || ex_rd !== 5'd0) begin
            n_fail++; $display("FAIL flush_hold_bubble got %b/%h/%h/%0d exp 0", ex_valid, ex_ctrl, ex_pc_plus4, ex_rd); end
        flush = 1'b0;
        hold  = 1'b0;
        set_id(1'b1, 32'h30C, 32'h1234, 5'd4, 5'd9, 5'd10, 1'b0, CtrlImm);
        step();
        hold = 1'b1;
        set_id(1'b1, 32'h400, 32'h9999, 5'd11, 5'd12, 5'd13, 1'b1, CtrlR);
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++; if (ex_valid !== 1'b1 || ex_ctrl !== CtrlImm || ex_pc_plus4 !== 32'h30C || ex_imm_ext !== 32'h1234 || ex_rs !== 5'd4) begin
                n_fail++; $display("FAIL hold_cycle%0d got %b/%h/%h/%h/%0d exp 1/8A/30C/1234/4", i, ex_valid, ex_ctrl, ex_pc_plus4, ex_imm_ext, ex_rs); end
        end
        hold = 1'b0;
    endtask

    task automatic test_saturation();
        int exp_cnt[5];
        exp_cnt = '{1, 2, 3, 3, 3};
        reset_n = 1'b0;
        set_id(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 8'h00);
        step();
        reset_n = 1'b1;
        // lw $5, 0($5): each copy depends on the one ahead of it
        set_id(1'b1, 32'h500, 32'h0, 5'd5, 5'd5, 5'd0, 1'b0, CtrlLw);
        step();
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (s_stall_out !== 1'b1) begin n_fail++; $display("FAIL sat_stall%0d got %b exp 1", i, s_stall_out); end
            step();
            n_tests++; if (s_stall_count !== 2'(exp_cnt[i])) begin
                n_fail++; $display("FAIL sat_count%0d got %0d exp %0d", i, s_stall_count, exp_cnt[i]); end
            step();
        end
        n_tests++; if (stall_count !== 16'd5) begin n_fail++; $display("FAIL sat_wide_count got %0d exp 5", stall_count); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_stall();
        test_flush_hold();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
